// File: rtl/sar_pkg.sv
// rtl/sar_pkg.sv - shared state encoding and default code width for the SAR sequencer
package sar_pkg;

  localparam int SAR_WIDTH = 10;

  typedef enum logic [1:0] {
    ST_IDLE        = 2'd0,
    ST_TRACK       = 2'd1,
    ST_CONVERT     = 2'd2,
    ST_WAIT_PERIOD = 2'd3
  } sar_state_e;

  localparam logic [1:0] S_IDLE        = ST_IDLE;
  localparam logic [1:0] S_TRACK       = ST_TRACK;
  localparam logic [1:0] S_CONVERT     = ST_CONVERT;
  localparam logic [1:0] S_WAIT_PERIOD = ST_WAIT_PERIOD;

endpackage

// File: rtl/sar_sample_sequencer_if.sv
// rtl/sar_sample_sequencer_if.sv - ADC control and result handshake bundle
interface sar_sample_sequencer_if import sar_pkg::*; #(
  parameter int WIDTH = SAR_WIDTH
);

  logic             enable;
  logic             hold_digital;
  logic             eoc;
  logic [WIDTH-1:0] adc_code;
  logic [WIDTH-1:0] result_data;
  logic             result_valid;
  logic             result_ready;
  logic             overrun;
  logic             timeout_err;
  logic [15:0]      sample_count;

  modport slave (
    input  enable, eoc, adc_code, result_ready,
    output hold_digital, result_data, result_valid, overrun, timeout_err, sample_count
  );

  modport master (
    output enable, eoc, adc_code, result_ready,
    input  hold_digital, result_data, result_valid, overrun, timeout_err, sample_count
  );

endinterface

// File: rtl/sar_result_buffer.sv
// rtl/sar_result_buffer.sv - single-entry result register with valid/ready handshake and overrun flag
module sar_result_buffer import sar_pkg::*; #(
  parameter int WIDTH = SAR_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             capture,
  input  logic [WIDTH-1:0] capture_data,
  input  logic             ready,
  output logic [WIDTH-1:0] data,
  output logic             valid,
  output logic             overrun
);

  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             overrun_q, overrun_d;

  always_comb begin
    data_d    = data_q;
    valid_d   = valid_q;
    overrun_d = 1'b0;
    if (capture) begin
      // a capture always wins; only an unread, unaccepted entry counts as lost
      data_d    = capture_data;
      valid_d   = 1'b1;
      overrun_d = valid_q & ~ready;
    end else if (valid_q && ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      data_q    <= data_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign data    = data_q;
  assign valid   = valid_q;
  assign overrun = overrun_q;

endmodule

// File: rtl/sar_sample_sequencer.sv
// rtl/sar_sample_sequencer.sv - periodic track/convert sequencer for a SAR ADC with timeout retry
module sar_sample_sequencer import sar_pkg::*; #(
  parameter int WIDTH        = SAR_WIDTH,
  parameter int TRACK_CYCLES = 4,
  parameter int PERIOD       = 64,
  parameter int TIMEOUT      = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  sar_sample_sequencer_if.slave  bus
);

  localparam int PCW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam int CCW = $clog2(TIMEOUT + 1);
  localparam logic [PCW-1:0] PERIOD_LAST = PCW'(PERIOD - 1);
  localparam logic [PCW-1:0] TRACK_LAST  = PCW'(TRACK_CYCLES - 1);
  localparam logic [CCW-1:0] CONV_LAST   = CCW'(TIMEOUT - 1);

  logic [1:0]     state_q, state_d;
  logic [PCW-1:0] period_cnt_q, period_cnt_d;
  logic [CCW-1:0] conv_cnt_q, conv_cnt_d;
  logic           eoc_q, eoc_d;
  logic           timeout_err_q, timeout_err_d;
  logic [15:0]    sample_count_q, sample_count_d;
  logic           eoc_rise;
  logic           capture;
  logic           enter_track;

  always_comb begin
    eoc_d         = bus.eoc;
    eoc_rise      = bus.eoc & ~eoc_q;
    state_d       = state_q;
    capture       = 1'b0;
    timeout_err_d = 1'b0;
    enter_track   = 1'b0;
    conv_cnt_d    = '0;
    case (state_q)
      S_IDLE: begin
        if (bus.enable) begin
          state_d     = S_TRACK;
          enter_track = 1'b1;
        end
      end
      S_TRACK: begin
        // the period counter restarts on TRACK entry, so it doubles as the track timer
        if (period_cnt_q == TRACK_LAST) state_d = S_CONVERT;
      end
      S_CONVERT: begin
        conv_cnt_d = conv_cnt_q + 1'b1;
        if (eoc_rise) begin
          capture = 1'b1;
          state_d = S_WAIT_PERIOD;
        end else if (conv_cnt_q == CONV_LAST) begin
          timeout_err_d = 1'b1;
          state_d       = S_TRACK;
          enter_track   = 1'b1;
        end
      end
      S_WAIT_PERIOD: begin
        if (period_cnt_q == PERIOD_LAST) begin
          if (bus.enable) begin
            state_d     = S_TRACK;
            enter_track = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (enter_track)                     period_cnt_d = '0;
    else if (period_cnt_q == PERIOD_LAST) period_cnt_d = period_cnt_q;
    else                                  period_cnt_d = period_cnt_q + 1'b1;

    sample_count_d = capture ? sample_count_q + 16'd1 : sample_count_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= S_IDLE;
      period_cnt_q   <= '0;
      conv_cnt_q     <= '0;
      eoc_q          <= 1'b0;
      timeout_err_q  <= 1'b0;
      sample_count_q <= '0;
    end else begin
      state_q        <= state_d;
      period_cnt_q   <= period_cnt_d;
      conv_cnt_q     <= conv_cnt_d;
      eoc_q          <= eoc_d;
      timeout_err_q  <= timeout_err_d;
      sample_count_q <= sample_count_d;
    end
  end

  sar_result_buffer #(.WIDTH(WIDTH)) u_result_buffer (
    .clk          (clk),
    .reset        (reset),
    .capture      (capture),
    .capture_data (bus.adc_code),
    .ready        (bus.result_ready),
    .data         (bus.result_data),
    .valid        (bus.result_valid),
    .overrun      (bus.overrun)
  );

  assign bus.hold_digital = (state_q == S_CONVERT);
  assign bus.timeout_err  = timeout_err_q;
  assign bus.sample_count = sample_count_q;

endmodule

// File: tb/tb_sar_sample_sequencer.sv
// tb/tb_sar_sample_sequencer.sv - directed scenarios checked against a timing model of the sequencer
module tb_sar_sample_sequencer;

  localparam int W   = 10;
  localparam int TC  = 4;
  localparam int PER = 64;
  localparam int TO  = 32;

  logic clk = 1'b0;
  logic reset = 1'b1;

  sar_sample_sequencer_if #(.WIDTH(W)) bus();

  sar_sample_sequencer #(
    .WIDTH(W), .TRACK_CYCLES(TC), .PERIOD(PER), .TIMEOUT(TO)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int ovr_seen = 0;
  int to_seen = 0;
  int valid_cyc = 0;

  // model: position within the current sampling period, counted from TRACK entry
  bit         m_active;
  bit         m_done;
  int         m_t;
  bit         m_eoc_prev;
  bit         m_valid;
  logic [W-1:0] m_data;
  bit         m_ovr;
  bit         m_to;
  int         m_count;

  function automatic bit m_hold();
    return m_active && !m_done && (m_t >= TC);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_active = 0; m_done = 0; m_t = 0; m_eoc_prev = 0;
    m_valid = 0; m_data = '0; m_ovr = 0; m_to = 0; m_count = 0;
  endtask

  task automatic model_step();
    bit in_conv;
    bit rise;
    bit cap;
    in_conv = m_hold();
    rise    = bus.eoc && !m_eoc_prev;
    cap     = 0;
    m_ovr   = 0;
    m_to    = 0;
    if (!m_active) begin
      if (bus.enable) begin m_active = 1; m_t = 0; m_done = 0; end
    end else if (in_conv && rise) begin
      cap = 1; m_done = 1; m_t++;
    end else if (in_conv && (m_t - TC == TO - 1)) begin
      m_to = 1; m_t = 0;
    end else if (m_done && m_t >= PER - 1) begin
      if (bus.enable) begin m_t = 0; m_done = 0; end
      else m_active = 0;
    end else begin
      m_t++;
    end
    if (cap) begin
      m_ovr   = m_valid && !bus.result_ready;
      m_data  = bus.adc_code;
      m_valid = 1;
      m_count = (m_count + 1) % 65536;
    end else if (m_valid && bus.result_ready) begin
      m_valid = 0;
    end
    m_eoc_prev = bus.eoc;
  endtask

  task automatic tick();
    if (reset) model_reset(); else model_step();
    @(posedge clk);
    #1;
    cyc++;
    chk("hold_digital", bus.hold_digital, m_hold());
    chk("result_valid", bus.result_valid, m_valid);
    chk("result_data", bus.result_data, m_data);
    chk("overrun", bus.overrun, m_ovr);
    chk("timeout_err", bus.timeout_err, m_to);
    chk("sample_count", bus.sample_count, m_count);
    if (bus.overrun === 1'b1) ovr_seen++;
    if (bus.timeout_err === 1'b1) to_seen++;
    if (bus.result_valid === 1'b1) valid_cyc++;
  endtask

  task automatic wait_hold(output int rc);
    int k = 0;
    while (bus.hold_digital !== 1'b1 && k < 200) begin
      tick();
      k++;
    end
    if (k == 200) begin
      tests++;
      fails++;
      $display("FAIL wait_hold: hold_digital still 0 after 200 cycles, expected 1");
    end
    rc = cyc;
  endtask

  // presents an eoc edge with the given code during the n-th CONVERT cycle
  task automatic finish_conv(input int n, input logic [W-1:0] code, input bit rdy, output int holds);
    holds = (bus.hold_digital === 1'b1) ? 1 : 0;
    repeat (n - 1) begin
      tick();
      if (bus.hold_digital === 1'b1) holds++;
    end
    bus.eoc = 1'b1;
    bus.adc_code = code;
    if (rdy) bus.result_ready = 1'b1;
    tick();
    if (bus.hold_digital === 1'b1) holds++;
    bus.eoc = 1'b0;
  endtask

  initial begin
    int r1, r2, h, k, v0, o0, t0, rel;
    bus.enable = 1'b0;
    bus.eoc = 1'b0;
    bus.adc_code = '0;
    bus.result_ready = 1'b1;
    model_reset();
    tick();
    tick();
    chk("rst_hold", bus.hold_digital, 0);
    chk("rst_valid", bus.result_valid, 0);
    chk("rst_data", bus.result_data, 0);
    chk("rst_count", bus.sample_count, 0);
    reset = 1'b0;
    tick();
    tick();

    // basic conversion and period spacing
    bus.enable = 1'b1;
    wait_hold(r1);
    v0 = valid_cyc;
    finish_conv(5, 10'h08A, 1'b1, h);
    chk("s1_hold_len", h, 5);
    chk("s1_data", bus.result_data, 10'h08A);
    chk("s1_valid", bus.result_valid, 1);
    chk("s1_count", bus.sample_count, 1);
    wait_hold(r2);
    chk("s1_valid_cycles", valid_cyc - v0, 1);
    chk("s1_period", r2 - r1, 64);
    finish_conv(5, 10'h155, 1'b1, h);

    // eoc never rises
    t0 = to_seen;
    wait_hold(r1);
    h = 0;
    k = 0;
    while (bus.hold_digital === 1'b1 && k < 100) begin
      h++;
      tick();
      k++;
    end
    chk("s2_hold_len", h, 32);
    chk("s2_timeout_now", bus.timeout_err, 1);
    wait_hold(r2);
    chk("s2_retry_spacing", r2 - r1, 36);
    chk("s2_timeout_pulses", to_seen - t0, 1);
    chk("s2_count", bus.sample_count, 2);

    // two captures with nobody consuming
    bus.result_ready = 1'b0;
    o0 = ovr_seen;
    finish_conv(3, 10'h184, 1'b0, h);
    wait_hold(r1);
    finish_conv(3, 10'h066, 1'b0, h);
    chk("s3_overrun_now", bus.overrun, 1);
    chk("s3_overrun_pulses", ovr_seen - o0, 1);
    chk("s3_data", bus.result_data, 10'h066);
    chk("s3_valid", bus.result_valid, 1);

    // capture coinciding with a transfer
    bus.result_ready = 1'b1;
    tick();
    bus.result_ready = 1'b0;
    chk("s4_drained", bus.result_valid, 0);
    wait_hold(r1);
    finish_conv(3, 10'h080, 1'b0, h);
    chk("s4_pending", bus.result_data, 10'h080);
    wait_hold(r1);
    o0 = ovr_seen;
    finish_conv(3, 10'h082, 1'b1, h);
    chk("s4_data", bus.result_data, 10'h082);
    chk("s4_valid", bus.result_valid, 1);
    chk("s4_no_overrun", ovr_seen - o0, 0);

    // reset three cycles into CONVERT
    wait_hold(r1);
    tick();
    tick();
    #2;
    reset = 1'b1;
    #1;
    chk("s5_hold", bus.hold_digital, 0);
    chk("s5_valid", bus.result_valid, 0);
    chk("s5_data", bus.result_data, 0);
    chk("s5_overrun", bus.overrun, 0);
    chk("s5_timeout", bus.timeout_err, 0);
    chk("s5_count", bus.sample_count, 0);
    model_reset();
    tick();
    tick();
    reset = 1'b0;
    rel = cyc;
    wait_hold(r1);
    chk("s5_restart", r1 - rel, 5);
    finish_conv(2, 10'h3C1, 1'b1, h);
    chk("s5_count_after", bus.sample_count, 1);
    chk("s5_data_after", bus.result_data, 10'h3C1);

    // enable dropped mid-conversion
    wait_hold(r1);
    bus.enable = 1'b0;
    finish_conv(4, 10'h2AA, 1'b1, h);
    chk("s6_hold_len", h, 4);
    chk("s6_count", bus.sample_count, 2);
    chk("s6_data", bus.result_data, 10'h2AA);
    h = 0;
    repeat (100) begin
      tick();
      if (bus.hold_digital === 1'b1) h++;
    end
    chk("s6_no_more_hold", h, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
